// File: rtl/snake_engine.sv
// Snake update engine: map clear, timed head advance, grow/erase through a body FIFO,
// fruit placement with RNG handshake and retry, and wall/self collision via map read-back.
module snake_engine #(
    parameter int MAPA_WIDTH  = 40,
    parameter int MAPA_HEIGHT = 30,
    parameter int COORD_W     = 10,
    parameter int MAX_LEN     = 128,
    parameter int TICK_INIT   = 50000000,
    parameter int TICK_MIN    = 5000000,
    parameter int TICK_STEP   = 2500000,
    parameter int START_X     = 10,
    parameter int START_Y     = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [1:0]                   dir,
    output logic                         map_renable,
    output logic [COORD_W-1:0]           map_rx,
    output logic [COORD_W-1:0]           map_ry,
    input  logic [1:0]                   map_rdata,
    output logic                         map_wenable,
    output logic [COORD_W-1:0]           map_wx,
    output logic [COORD_W-1:0]           map_wy,
    output logic [1:0]                   map_wdata,
    output logic                         fruta_req,
    input  logic                         fruta_ack,
    input  logic [COORD_W-1:0]           fruta_x,
    input  logic [COORD_W-1:0]           fruta_y,
    output logic [15:0]                  score,
    output logic [$clog2(MAX_LEN):0]     length,
    output logic                         game_over,
    output logic                         busy
);
    localparam int LW = $clog2(MAX_LEN) + 1;
    localparam int PW = $clog2(MAX_LEN);
    typedef logic [COORD_W-1:0] coord_t;
    localparam coord_t X_MAX = coord_t'(MAPA_WIDTH - 1);
    localparam coord_t Y_MAX = coord_t'(MAPA_HEIGHT - 1);
    localparam coord_t SX    = coord_t'(START_X);
    localparam coord_t SY    = coord_t'(START_Y);
    localparam logic [31:0] T_INIT = 32'(TICK_INIT);
    localparam logic [31:0] T_MIN  = 32'(TICK_MIN);
    localparam logic [31:0] T_STEP = 32'(TICK_STEP);

    typedef enum logic [3:0] {
        S_CLEAR, S_FRUIT_REQ, S_FRUIT_WAIT, S_FRUIT_CHECK, S_IDLE,
        S_MOVE, S_MOVE_WAIT, S_CHECK, S_WRITE_HEAD, S_ERASE_TAIL, S_GAME_OVER
    } state_t;

    state_t            state;
    coord_t            cx, cy, hx, hy, nhx, nhy, tx, ty, fx, fy, px, py;
    logic [1:0]        cur_dir, nd;
    logic [31:0]       tick, cnt;
    logic              eat, fruit_pend, f_oob;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [2*COORD_W-1:0] fifo [MAX_LEN];
    logic [2*COORD_W-1:0] tail, fifo_wd;
    logic [PW-1:0]     fifo_wa;
    logic              fifo_we, fruit_in_range;

    assign tail = fifo[rd_ptr];
    assign fruit_in_range = (fruta_x < coord_t'(MAPA_WIDTH)) && (fruta_y < coord_t'(MAPA_HEIGHT));

    // Opposite direction differs only in bit 0; reversing onto the neck is ignored.
    always_comb begin
        nd = dir;
        if (length > LW'(1) && dir == {cur_dir[1], ~cur_dir[0]})
            nd = cur_dir;
        px = hx;
        py = hy;
        case (nd)
            2'd0: py = (hy == '0)    ? Y_MAX : hy - coord_t'(1);
            2'd1: py = (hy == Y_MAX) ? '0    : hy + coord_t'(1);
            2'd2: px = (hx == '0)    ? X_MAX : hx - coord_t'(1);
            default: px = (hx == X_MAX) ? '0 : hx + coord_t'(1);
        endcase
    end

    // Body FIFO: slot 0 is re-seeded with the start cell while clearing.
    always_comb begin
        fifo_we = (state == S_CLEAR) || (state == S_WRITE_HEAD);
        fifo_wa = (state == S_CLEAR) ? '0 : wr_ptr;
        fifo_wd = (state == S_CLEAR) ? {SY, SX} : {nhy, nhx};
    end

    always_ff @(posedge clk) begin
        if (fifo_we)
            fifo[fifo_wa] <= fifo_wd;
    end

    always_ff @(posedge clk) begin
        if (reset || (state == S_GAME_OVER && start)) begin
            state       <= S_CLEAR;
            map_wenable <= 1'b0;
            map_renable <= 1'b0;
            map_wx      <= '0;
            map_wy      <= '0;
            map_wdata   <= 2'b00;
            map_rx      <= '0;
            map_ry      <= '0;
            fruta_req   <= 1'b0;
            score       <= '0;
            length      <= LW'(1);
            game_over   <= 1'b0;
            busy        <= 1'b1;
            tick        <= T_INIT;
            cnt         <= '0;
            hx          <= SX;
            hy          <= SY;
            nhx         <= '0;
            nhy         <= '0;
            tx          <= '0;
            ty          <= '0;
            fx          <= '0;
            fy          <= '0;
            cur_dir     <= 2'd3;
            cx          <= '0;
            cy          <= '0;
            wr_ptr      <= PW'(1);
            rd_ptr      <= '0;
            eat         <= 1'b0;
            fruit_pend  <= 1'b0;
            f_oob       <= 1'b0;
        end else begin
            map_wenable <= 1'b0;
            map_renable <= 1'b0;
            case (state)
                S_CLEAR: begin
                    map_wenable <= 1'b1;
                    map_wx      <= cx;
                    map_wy      <= cy;
                    map_wdata   <= (cx == SX && cy == SY) ? 2'b01 : 2'b00;
                    if (cx == X_MAX) begin
                        cx <= '0;
                        if (cy == Y_MAX) begin
                            state     <= S_FRUIT_REQ;
                            fruta_req <= 1'b1;
                        end else begin
                            cy <= cy + coord_t'(1);
                        end
                    end else begin
                        cx <= cx + coord_t'(1);
                    end
                end
                S_FRUIT_REQ: begin
                    busy <= 1'b0;
                    if (fruta_ack) begin
                        fruta_req <= 1'b0;
                        fx        <= fruta_x;
                        fy        <= fruta_y;
                        f_oob     <= !fruit_in_range;
                        // Out-of-range candidates are never put on the RAM bus.
                        map_renable <= fruit_in_range;
                        map_rx      <= fruta_x;
                        map_ry      <= fruta_y;
                        state       <= S_FRUIT_WAIT;
                    end
                end
                S_FRUIT_WAIT: state <= S_FRUIT_CHECK;
                S_FRUIT_CHECK: begin
                    if (f_oob || map_rdata != 2'b00) begin
                        fruta_req <= 1'b1;
                        state     <= S_FRUIT_REQ;
                    end else begin
                        map_wenable <= 1'b1;
                        map_wx      <= fx;
                        map_wy      <= fy;
                        map_wdata   <= 2'b10;
                        state       <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (cnt == tick - 32'd1) begin
                        cnt   <= '0;
                        state <= S_MOVE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_MOVE: begin
                    cur_dir     <= nd;
                    nhx         <= px;
                    nhy         <= py;
                    map_renable <= 1'b1;
                    map_rx      <= px;
                    map_ry      <= py;
                    state       <= S_MOVE_WAIT;
                end
                S_MOVE_WAIT: state <= S_CHECK;
                S_CHECK: begin
                    case (map_rdata)
                        2'b11: begin
                            game_over <= 1'b1;
                            state     <= S_GAME_OVER;
                        end
                        // A body hit is legal only on the tail, which vacates this tick.
                        2'b01: begin
                            eat <= 1'b0;
                            if ({nhy, nhx} == tail) begin
                                state <= S_WRITE_HEAD;
                            end else begin
                                game_over <= 1'b1;
                                state     <= S_GAME_OVER;
                            end
                        end
                        2'b10: begin
                            eat   <= 1'b1;
                            state <= S_WRITE_HEAD;
                        end
                        default: begin
                            eat   <= 1'b0;
                            state <= S_WRITE_HEAD;
                        end
                    endcase
                end
                S_WRITE_HEAD: begin
                    map_wenable <= 1'b1;
                    map_wx      <= nhx;
                    map_wy      <= nhy;
                    map_wdata   <= 2'b01;
                    hx          <= nhx;
                    hy          <= nhy;
                    wr_ptr      <= wr_ptr + PW'(1);
                    // Latch the tail now: a full FIFO push overwrites its slot.
                    tx          <= tail[COORD_W-1:0];
                    ty          <= tail[2*COORD_W-1:COORD_W];
                    if (eat && score != 16'hFFFF)
                        score <= score + 16'd1;
                    if (eat && length < LW'(MAX_LEN)) begin
                        length    <= length + LW'(1);
                        tick      <= (tick < T_MIN + T_STEP) ? T_MIN : tick - T_STEP;
                        fruta_req <= 1'b1;
                        state     <= S_FRUIT_REQ;
                    end else begin
                        rd_ptr     <= rd_ptr + PW'(1);
                        fruit_pend <= eat;
                        state      <= S_ERASE_TAIL;
                    end
                end
                S_ERASE_TAIL: begin
                    if (!(tx == hx && ty == hy)) begin
                        map_wenable <= 1'b1;
                        map_wx      <= tx;
                        map_wy      <= ty;
                        map_wdata   <= 2'b00;
                    end
                    if (fruit_pend) begin
                        fruit_pend <= 1'b0;
                        fruta_req  <= 1'b1;
                        state      <= S_FRUIT_REQ;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_GAME_OVER: state <= S_GAME_OVER;
                default:     state <= S_CLEAR;
            endcase
        end
    end
endmodule

// File: doc/snake_engine.md
Name: snake_engine

Overview:
- Parametrised successor of the snake update engine: map clear, periodic head advance, grow/erase, fruit placement and collisions, all driven through a 2-bit-per-cell map RAM.
- Adds over the previous generation: self-collision via map read-back, reverse-direction rejection, fruit request/ack handshake with occupied-cell retry, bounded body FIFO, and speed-up per fruit.
- Sits between the direction/keyboard logic, the fruit RNG block and the dual-port map RAM read by the VGA renderer.

Parameters:
- MAPA_WIDTH, 40, map columns.
- MAPA_HEIGHT, 30, map rows.
- COORD_W, 10, coordinate width.
- MAX_LEN, 128, body FIFO depth, power of two, max snake length.
- TICK_INIT, 50000000, clocks per move at start.
- TICK_MIN, 5000000, fastest allowed tick.
- TICK_STEP, 2500000, tick reduction per fruit eaten.
- START_X, 10, initial head column.
- START_Y, 10, initial head row.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  pulse; leaves GAME_OVER and restarts the game
- dir  in  2  requested direction: 0 up, 1 down, 2 left, 3 right
- map_renable  out  1  map read strobe
- map_rx, map_ry  out  COORD_W each  read address
- map_rdata  in  2  cell value, valid exactly 1 clk after map_renable
- map_wenable  out  1  map write strobe, one cell per clk
- map_wx, map_wy  out  COORD_W each  write address
- map_wdata  out  2  00 empty, 01 snake, 10 fruit, 11 obstacle
- fruta_req  out  1  held high until fruta_ack
- fruta_ack  in  1  fruta_x/fruta_y valid this cycle
- fruta_x, fruta_y  in  COORD_W each  candidate fruit cell
- score  out  16  fruits eaten, saturates at 16'hFFFF
- length  out  $clog2(MAX_LEN)+1  current snake length
- game_over  out  1  high while in GAME_OVER
- busy  out  1  high in CLEAR

Behaviour:
- Reset (and any start pulse from GAME_OVER): all strobes 0, fruta_req 0, score 0, length 1, game_over 0, tick = TICK_INIT, head = (START_X, START_Y), current dir = 3. Go to CLEAR.
- Reset asserted mid-operation aborts any state, including a pending fruit handshake, on the next edge.
- CLEAR: raster sweep x fastest, one write per clk, MAPA_WIDTH*MAPA_HEIGHT cycles. Writes 01 at the start cell, 00 elsewhere. Then FRUIT_REQ.
- IDLE: count clks; when counter reaches tick-1, go to MOVE.
- dir is sampled in MOVE. A request exactly opposite the current dir (0<->1, 2<->3) is ignored while length > 1.
- MOVE: compute the next head with wrap-around (x == 0 moving left -> MAPA_WIDTH-1, etc.). Issue a map read at the next head. Go to CHECK.
- CHECK (rdata valid):
  - 11 -> GAME_OVER.
  - 01 -> GAME_OVER, except when the cell equals the current tail and the move does not grow the snake (tail vacates this tick); that move is legal.
  - 10 -> eat = 1.
  - 00 -> eat = 0.
- WRITE_HEAD: write 01 at the new head; push it into the FIFO.
  - If eat and length < MAX_LEN: length += 1, score += 1, tick = max(tick - TICK_STEP, TICK_MIN). Go to FRUIT_REQ.
  - If eat and length == MAX_LEN: score += 1, tail is popped (no growth). Go to ERASE_TAIL.
  - Otherwise go to ERASE_TAIL.
- ERASE_TAIL: write 00 at the popped tail, unless it equals the new head (tail-chase case; write suppressed). Then IDLE, or FRUIT_REQ if a fruit was eaten at max length.
- FRUIT_REQ: fruta_req = 1 until the fruta_ack cycle. Capture the coordinates and drop the request the cycle after the ack. Issue a map read at the captured cell.
- FRUIT_CHECK: if rdata != 00, re-enter FRUIT_REQ; otherwise write 10 at the cell and go to IDLE.
- GAME_OVER: no map writes; score and length held. The start pulse takes the reset path above.
- map_wenable and map_renable are never both asserted for the same cell in the same cycle.
- Coordinates out of range from the RNG (x >= MAPA_WIDTH or y >= MAPA_HEIGHT) are treated as occupied (retry).

Test Plan:
- Reset release, MAPA 40x30 -> exactly 1200 write cycles: 01 at (10,10), 00 elsewhere, busy high throughout; then fruta_req rises.
- TICK_INIT=4, dir=3, fruit acked at (20,5) -> after 4 idle clks, write 01 at (11,10), then write 00 at (10,10); length stays 1.
- Head at (39,10), dir=3 -> next head (0,10); head at (5,0), dir=0 -> next head (5,29).
- Fruit at (11,10), dir=3 -> score 1, length 2, tick reduced by TICK_STEP, no tail erase, fruta_req re-asserted. First ack at (11,10) (snake) -> retried; second ack (3,3) -> 10 written at (3,3).
- Length 5 snake turned into its own body (not the tail) -> game_over=1, no further map writes; start pulse -> CLEAR sweep, score 0.
- Length 3 moving right, dir=2 -> ignored, head continues right; with length 1, dir=2 -> accepted.
